// File: rtl/hsv_core_commit.sv
// hsv_core_commit: in-order retirement stage that writes the register file and drives the ctrlstatus sideband.
// Optional feature: define HSV_CORE_COMMIT_MISALIGN_TRAP_EN to turn misaligned jump targets into traps.
// in_data packs NUM_UNITS commit_data_t records; unit i sits at [i*CW +: CW], with fields ordered MSB-first:
// token, pc, next_pc, rd, rd_value, writeback, trap, trap_cause, trap_value, mode_return, jump, irq_boundary.
module hsv_core_commit #(
  parameter int unsigned NUM_UNITS = 5,
  parameter int unsigned TOKEN_W   = 4
) (
  input  logic                                 clk_core,
  input  logic                                 rst_core,
  input  logic                                 flush_req,
  output logic                                 flush_ack,
  input  logic [NUM_UNITS*(TOKEN_W+143)-1:0]   in_data,
  input  logic [NUM_UNITS-1:0]                 in_valid,
  output logic [NUM_UNITS-1:0]                 in_ready,
  output logic [TOKEN_W-1:0]                   commit_token,
  output logic                                 rf_wr_en,
  output logic [4:0]                           rf_wr_addr,
  output logic [31:0]                          rf_wr_data,
  output logic                                 ctrl_commit,
  output logic                                 ctrl_flush_begin,
  output logic                                 ctrl_trap,
  output logic [4:0]                           ctrl_trap_cause,
  output logic [31:0]                          ctrl_trap_value,
  output logic                                 ctrl_mode_return,
  output logic [31:0]                          ctrl_next_pc,
  input  logic                                 ctrl_wait_irq,
  input  logic                                 ctrl_begin_irq
);

  typedef struct packed {
    logic [TOKEN_W-1:0] token;
    logic [31:0]        pc;
    logic [31:0]        next_pc;
    logic [4:0]         rd;
    logic [31:0]        rd_value;
    logic               writeback;
    logic               trap;
    logic [4:0]         trap_cause;
    logic [31:0]        trap_value;
    logic               mode_return;
    logic               jump;
    logic               irq_boundary;
  } commit_data_t;

  localparam int unsigned CW = $bits(commit_data_t);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  commit_data_t         units [NUM_UNITS];
  logic [NUM_UNITS-1:0] match;
  logic [NUM_UNITS-1:0] grant;
  logic                 sel_found;
  commit_data_t         sel;
  logic                 accept;
  logic                 misalign;
  logic                 trap_eff;
  logic [4:0]           trap_cause_eff;
  logic [31:0]          trap_value_eff;
  logic                 redirect;

  logic [TOKEN_W-1:0]   token_q, token_d;
  logic                 flush_ack_q, flush_ack_d;
  logic                 rf_wr_en_q, rf_wr_en_d;
  logic [4:0]           rf_wr_addr_q, rf_wr_addr_d;
  logic [31:0]          rf_wr_data_q, rf_wr_data_d;
  logic                 commit_q, commit_d;
  logic                 flush_begin_q, flush_begin_d;
  logic                 trap_q, trap_d;
  logic [4:0]           trap_cause_q, trap_cause_d;
  logic [31:0]          trap_value_q, trap_value_d;
  logic                 mode_return_q, mode_return_d;
  logic [31:0]          next_pc_q, next_pc_d;

  // ctrl_begin_irq only orders events inside the ctrlstatus FSM; pc is carried for tracing only.
  logic unused_ok;
  assign unused_ok = ^{ctrl_begin_irq, sel.pc};

  // Unpack producer records and flag the ones holding the expected token.
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(NUM_UNITS); i++) begin
      units[i] = in_data[i*CW +: CW];
      match[i] = in_valid[i] && (units[i].token == token_q);
    end
  end

  // Lowest matching index wins; the descending scan lets the lowest overwrite last.
  always_comb begin
    grant     = '0;
    sel_found = 1'b0;
    sel       = '0;
    for (int i = int'(NUM_UNITS) - 1; i >= 0; i--) begin
      if (match[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        sel_found = 1'b1;
        sel       = units[i];
      end
    end
  end

`ifdef HSV_CORE_COMMIT_MISALIGN_TRAP_EN
  assign misalign = sel.jump && !sel.trap && (sel.next_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign trap_eff       = sel.trap || misalign;
  assign trap_cause_eff = misalign ? 5'd0 : sel.trap_cause;
  assign trap_value_eff = misalign ? sel.next_pc : sel.trap_value;
  assign redirect       = sel.jump || trap_eff || sel.mode_return;

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else if (accept && redirect) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!flush_req) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Handshake and next values of every registered output.
  always_comb begin
    accept        = 1'b0;
    in_ready      = '0;
    token_d       = token_q;
    flush_ack_d   = 1'b0;
    commit_d      = 1'b0;
    rf_wr_en_d    = 1'b0;
    rf_wr_addr_d  = rf_wr_addr_q;
    rf_wr_data_d  = rf_wr_data_q;
    flush_begin_d = 1'b0;
    trap_d        = 1'b0;
    mode_return_d = 1'b0;
    trap_cause_d  = trap_cause_q;
    trap_value_d  = trap_value_q;
    next_pc_d     = next_pc_q;

    if ((state_q == ST_RUN) && !flush_req && sel_found &&
        (!ctrl_wait_irq || sel.irq_boundary)) begin
      accept = 1'b1;
    end
    if (accept) begin
      in_ready      = grant;
      token_d       = token_q + TOKEN_W'(1);
      commit_d      = 1'b1;
      rf_wr_en_d    = sel.writeback && !trap_eff && (sel.rd != 5'd0);
      flush_begin_d = redirect;
      trap_d        = trap_eff;
      mode_return_d = sel.mode_return;
      trap_cause_d  = trap_cause_eff;
      trap_value_d  = trap_value_eff;
      next_pc_d     = sel.next_pc;
      if (rf_wr_en_d) begin
        rf_wr_addr_d = sel.rd;
        rf_wr_data_d = sel.rd_value;
      end
    end
    // The token restarts while the pipeline is being flushed.
    if (state_d == ST_FLUSH) begin
      token_d     = '0;
      flush_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      token_q       <= '0;
      flush_ack_q   <= 1'b0;
      commit_q      <= 1'b0;
      rf_wr_en_q    <= 1'b0;
      rf_wr_addr_q  <= '0;
      rf_wr_data_q  <= '0;
      flush_begin_q <= 1'b0;
      trap_q        <= 1'b0;
      trap_cause_q  <= '0;
      trap_value_q  <= '0;
      mode_return_q <= 1'b0;
      next_pc_q     <= '0;
    end else begin
      token_q       <= token_d;
      flush_ack_q   <= flush_ack_d;
      commit_q      <= commit_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_wr_addr_q  <= rf_wr_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      flush_begin_q <= flush_begin_d;
      trap_q        <= trap_d;
      trap_cause_q  <= trap_cause_d;
      trap_value_q  <= trap_value_d;
      mode_return_q <= mode_return_d;
      next_pc_q     <= next_pc_d;
    end
  end

  assign commit_token     = token_q;
  assign flush_ack        = flush_ack_q;
  assign ctrl_commit      = commit_q;
  assign rf_wr_en         = rf_wr_en_q;
  assign rf_wr_addr       = rf_wr_addr_q;
  assign rf_wr_data       = rf_wr_data_q;
  assign ctrl_flush_begin = flush_begin_q;
  assign ctrl_trap        = trap_q;
  assign ctrl_trap_cause  = trap_cause_q;
  assign ctrl_trap_value  = trap_value_q;
  assign ctrl_mode_return = mode_return_q;
  assign ctrl_next_pc     = next_pc_q;

endmodule
